// File: rtl/data_sram_axi_bridge.sv
// Uncached SRAM-style data port -> single-beat AXI read/write, one outstanding; data_ok 3 cycles after req at zero wait.
// Each AXI valid is held until its own handshake; BRIDGE_EARLY_WRITE_ACK_EN acks writes once AW and W are both accepted.
module data_sram_axi_bridge #(
   parameter int ID_W    = 4,
   parameter int DATA_ID = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req,
   input  logic            wr,
   input  logic [1:0]      size,
   input  logic [31:0]     addr,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   output logic [31:0]     rdata,
   output logic            addr_ok,
   output logic            data_ok,
   output logic            bus_err,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [31:0]     rdata_i,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [7:0]      awlen,
   output logic [2:0]      awsize,
   output logic [1:0]      awburst,
   output logic            awvalid,
   input  logic            awready,
   output logic [31:0]     wdata_o,
   output logic [3:0]      wstrb_o,
   output logic            wlast,
   output logic            wvalid,
   input  logic            wready,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_AW, S_WR_B} state_t;

   state_t      state_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] rdata_q;
   logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic        data_ok_q, bus_err_q;
   logic        aw_done_d, w_done_d;

   // A channel counts as done if it already handshook or is handshaking now.
   assign aw_done_d = !awvalid_q || awready;
   assign w_done_d  = !wvalid_q  || wready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         size_q    <= 2'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         rdata_q   <= 32'd0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         data_ok_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         data_ok_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  size_q  <= size;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
                  if (wr) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR_AW;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_A;
                  end
               end
            end
            S_RD_A: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_D;
               end
            end
            S_RD_D: begin
               if (rvalid) begin
                  if (rresp != 2'b00) bus_err_q <= 1'b1;
                  if (rlast) begin
                     rready_q  <= 1'b0;
                     rdata_q   <= rdata_i;
                     data_ok_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end
            end
            S_WR_AW: begin
               if (awready) awvalid_q <= 1'b0;
               if (wready)  wvalid_q  <= 1'b0;
               if (aw_done_d && w_done_d) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_B;
`ifdef BRIDGE_EARLY_WRITE_ACK_EN
                  data_ok_q <= 1'b1;
`endif
               end
            end
            S_WR_B: begin
               if (bvalid) begin
                  if (bresp != 2'b00) bus_err_q <= 1'b1;
                  bready_q <= 1'b0;
                  state_q  <= S_IDLE;
`ifndef BRIDGE_EARLY_WRITE_ACK_EN
                  data_ok_q <= 1'b1;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign addr_ok = req && (state_q == S_IDLE);
   assign data_ok = data_ok_q;
   assign rdata   = rdata_q;
   assign bus_err = bus_err_q;

   assign arid    = ID_W'(DATA_ID);
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;

   assign awid    = ID_W'(DATA_ID);
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awvalid = awvalid_q;
   assign wdata_o = wdata_q;
   assign wstrb_o = wstrb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: programmable-latency AXI slave, transaction-level reference model, latency literals.
module tb_data_sram_axi_bridge;
   localparam int ID_W    = 4;
   localparam int DATA_ID = 1;
`ifdef BRIDGE_EARLY_WRITE_ACK_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            resetn = 1'b0;
   logic            req = 1'b0, wr = 1'b0;
   logic [1:0]      size = 2'd0;
   logic [31:0]     addr = 32'd0, wdata = 32'd0;
   logic [3:0]      wstrb = 4'd0;
   logic [31:0]     rdata;
   logic            addr_ok, data_ok, bus_err;
   logic [ID_W-1:0] arid, awid;
   logic [31:0]     araddr, awaddr, wdata_o;
   logic [7:0]      arlen, awlen;
   logic [2:0]      arsize, awsize;
   logic [1:0]      arburst, awburst;
   logic            arvalid, rready, awvalid, wvalid, wlast, bready;
   logic [3:0]      wstrb_o;
   logic            arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
   logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [31:0]     rdata_i = 32'd0;
   logic [1:0]      rresp = 2'd0, bresp = 2'd0;

   data_sram_axi_bridge #(.ID_W(ID_W), .DATA_ID(DATA_ID)) dut (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
      .bus_err(bus_err), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata_i(rdata_i),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
      .bready(bready)
   );

   int n_vec = 0, n_miss = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Slave configuration and wait counters
   int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [31:0] r_val = 32'd0;
   logic [1:0]  r_rsp = 2'd0, b_rsp = 2'd0;
   logic        spurious = 1'b0;

   always @(posedge clk) begin
      #2;
      arready = arvalid && (ar_wait >= ar_dly);
      rvalid  = (rready && (r_wait >= r_dly)) || spurious;
      rlast   = rvalid;
      rdata_i = rvalid ? r_val : 32'h0BAD_0BAD;
      rresp   = rvalid ? r_rsp : 2'b00;
      awready = awvalid && (aw_wait >= aw_dly);
      wready  = wvalid && (w_wait >= w_dly);
      bvalid  = (bready && (b_wait >= b_dly)) || spurious;
      bresp   = bvalid ? b_rsp : 2'b00;
   end

   // Reference model: outstanding request and which of its handshakes are still owed
   logic        m_busy = 0, m_wr = 0, m_a_pend = 0, m_w_pend = 0;
   logic        m_dok = 0, m_dok_rd = 0, m_err = 0;
   logic [1:0]  m_size = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
   logic [3:0]  m_wstrb = 0;
   int acc_cyc = 0, acc_cnt = 0, dok_cyc = 0, dok_cnt = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
   logic [31:0] dok_rdata = 0;
   logic [2:0]  size_seen = 0;

   always @(negedge clk) begin
      if (!resetn) begin
         chk1("rst_arvalid", arvalid, 1'b0);
         chk1("rst_rready", rready, 1'b0);
         chk1("rst_awvalid", awvalid, 1'b0);
         chk1("rst_wvalid", wvalid, 1'b0);
         chk1("rst_bready", bready, 1'b0);
         chk1("rst_data_ok", data_ok, 1'b0);
         chk1("rst_bus_err", bus_err, 1'b0);
         chk("rst_rdata", rdata, 32'd0);
         m_busy = 0; m_a_pend = 0; m_w_pend = 0; m_dok = 0; m_dok_rd = 0; m_err = 0; m_rdata = 0;
         ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      end else begin
         chk1("addr_ok", addr_ok, req && !m_busy);
         chk1("arvalid", arvalid, m_busy && !m_wr && m_a_pend);
         chk1("rready", rready, m_busy && !m_wr && !m_a_pend);
         chk1("awvalid", awvalid, m_busy && m_wr && m_a_pend);
         chk1("wvalid", wvalid, m_busy && m_wr && m_w_pend);
         chk1("bready", bready, m_busy && m_wr && !m_a_pend && !m_w_pend);
         chk1("data_ok", data_ok, m_dok);
         chk1("bus_err", bus_err, m_err);
         if (m_dok_rd) chk("rdata", rdata, m_rdata);
         if (m_busy && !m_wr && m_a_pend) begin
            chk("araddr", araddr, m_addr);
            chk("arsize", 32'(arsize), 32'(m_size));
            chk("arlen_burst", {22'd0, arlen, arburst}, 32'd1);
            chk("arid", 32'(arid), 32'(DATA_ID));
         end
         if (m_busy && m_wr && m_a_pend) begin
            chk("awaddr", awaddr, m_addr);
            chk("awsize", 32'(awsize), 32'(m_size));
            chk("awlen_burst", {22'd0, awlen, awburst}, 32'd1);
            chk("awid", 32'(awid), 32'(DATA_ID));
         end
         if (m_busy && m_wr && m_w_pend) begin
            chk("wdata", wdata_o, m_wdata);
            chk("wstrb_last", {27'd0, wstrb_o, wlast}, {27'd0, m_wstrb, 1'b1});
         end
         if (req && addr_ok) begin acc_cyc = cyc; acc_cnt++; end
         if (data_ok) begin dok_cyc = cyc; dok_cnt++; dok_rdata = rdata; end
         if (arvalid && arready) size_seen = arsize;
         if (awvalid && awready) begin aw_hs_cyc = cyc; size_seen = awsize; end
         if (wvalid && wready) w_hs_cyc = cyc;
         // Advance model to the state after the coming clock edge
         m_dok = 0; m_dok_rd = 0;
         if (!m_busy) begin
            if (req) begin
               m_busy = 1; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
               m_a_pend = 1; m_w_pend = wr;
            end
         end else if (!m_wr) begin
            if (m_a_pend) begin
               if (arready) m_a_pend = 0;
            end else if (rvalid) begin
               if (rresp != 2'b00) m_err = 1;
               if (rlast) begin m_busy = 0; m_dok = 1; m_dok_rd = 1; m_rdata = rdata_i; end
            end
         end else if (m_a_pend || m_w_pend) begin
            if (awready) m_a_pend = 0;
            if (wready) m_w_pend = 0;
            if (!m_a_pend && !m_w_pend && EARLY) m_dok = 1;
         end else if (bvalid) begin
            if (bresp != 2'b00) m_err = 1;
            m_busy = 0;
            if (!EARLY) m_dok = 1;
         end
         if (arvalid && arready) ar_wait = 0; else if (arvalid) ar_wait++;
         if (rready && rvalid) r_wait = 0; else if (rready) r_wait++;
         if (awvalid && awready) aw_wait = 0; else if (awvalid) aw_wait++;
         if (wvalid && wready) w_wait = 0; else if (wvalid) w_wait++;
         if (bready && bvalid) b_wait = 0; else if (bready) b_wait++;
      end
   end

   task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
      req = 1'b1; wr = w; size = sz; addr = a; wdata = wd; wstrb = st;
   endtask

   task automatic wait_acc();
      int c0 = acc_cnt;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk); #1;
         if (acc_cnt != c0) return;
      end
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_dok(input int target);
      for (int k = 0; k < 60; k++) begin
         if (dok_cnt >= target) return;
         @(negedge clk); #1;
      end
      chk("data_ok_timeout", 32'(dok_cnt), 32'(target));
   endtask

   typedef struct {
      logic w; logic [1:0] sz; logic [31:0] a, wd; logic [3:0] st;
      int a_dly, w_dly, d_dly; logic [1:0] rsp; logic [31:0] rv;
      int lat_n, lat_e, aw_rel, w_rel; logic err;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, a1, a2, a3, d1, t0;
      vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0010, 32'd0, 4'hF, 0, 0, 1, 2'b00, 32'hDEAD_BEEF, 4, 4, 0, 0, 1'b0};
      vecs[1] = '{1'b1, 2'd0, 32'h0000_0103, 32'hAA00_0000, 4'b1000, 2, 0, 0, 2'b00, 32'd0, 5, 4, 3, 1, 1'b0};
      vecs[2] = '{1'b1, 2'd1, 32'h0000_2002, 32'h1234_0000, 4'b1100, 0, 3, 1, 2'b00, 32'd0, 7, 5, 1, 4, 1'b0};
      vecs[3] = '{1'b0, 2'd1, 32'h8000_0006, 32'd0, 4'hF, 2, 0, 0, 2'b00, 32'h0000_BEEF, 5, 5, 0, 0, 1'b0};
      vecs[4] = '{1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 1, 1, 0, 2'b10, 32'd0, 4, 3, 2, 2, 1'b1};
      vecs[5] = '{1'b0, 2'd0, 32'h0000_0041, 32'd0, 4'hF, 0, 0, 0, 2'b01, 32'h0000_0055, 3, 3, 0, 0, 1'b1};

      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      repeat (2) @(posedge clk);

      // Stray R/B beats while idle must be ignored, error responses included
      d0 = dok_cnt;
      #1 spurious = 1'b1; r_rsp = 2'b11; b_rsp = 2'b10;
      repeat (3) @(posedge clk);
      #1 spurious = 1'b0; r_rsp = 2'b00; b_rsp = 2'b00;
      repeat (2) @(negedge clk);
      #1 chk1("spurious_bus_err", bus_err, 1'b0);
      chk("spurious_no_dok", 32'(dok_cnt), 32'(d0));

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         if (vecs[i].w) begin
            aw_dly = vecs[i].a_dly; w_dly = vecs[i].w_dly; b_dly = vecs[i].d_dly; b_rsp = vecs[i].rsp;
         end else begin
            ar_dly = vecs[i].a_dly; r_dly = vecs[i].d_dly; r_rsp = vecs[i].rsp; r_val = vecs[i].rv;
         end
         d0 = dok_cnt;
         drive(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].st);
         wait_acc();
         @(posedge clk); #1 req = 1'b0;
         wait_dok(d0 + 1);
         chk($sformatf("v%0d_latency", i), 32'(dok_cyc - acc_cyc), 32'(EARLY && vecs[i].w ? vecs[i].lat_e : vecs[i].lat_n));
         chk($sformatf("v%0d_axsize", i), 32'(size_seen), {30'd0, vecs[i].sz});
         if (vecs[i].w) begin
            chk($sformatf("v%0d_aw_hs", i), 32'(aw_hs_cyc - acc_cyc), 32'(vecs[i].aw_rel));
            chk($sformatf("v%0d_w_hs", i), 32'(w_hs_cyc - acc_cyc), 32'(vecs[i].w_rel));
         end else begin
            chk($sformatf("v%0d_rdata", i), dok_rdata, vecs[i].rv);
         end
         repeat (vecs[i].d_dly + 3) @(posedge clk);
         #1 chk1($sformatf("v%0d_bus_err", i), bus_err, vecs[i].err);
         r_rsp = 2'b00; b_rsp = 2'b00;
      end

      // Back-to-back read, write, read with req held high; slow B response
      @(posedge clk); #1;
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 3; r_val = 32'h0123_4567;
      d0 = dok_cnt;
      drive(1'b0, 2'd2, 32'h0000_0100, 32'd0, 4'hF);
      wait_acc(); a1 = acc_cyc;
      @(posedge clk); #1 drive(1'b1, 2'd2, 32'h0000_0104, 32'h5A5A_A5A5, 4'hF);
      wait_acc(); a2 = acc_cyc; d1 = dok_cyc;
      chk("b2b_rd_latency", 32'(d1 - a1), 32'd3);
      chk("b2b_accept_on_dok", 32'(a2 - a1), 32'd3);
      chk("b2b_rd_rdata", dok_rdata, 32'h0123_4567);
      @(posedge clk); #1 drive(1'b0, 2'd2, 32'h0000_0108, 32'd0, 4'hF);
      wait_acc(); a3 = acc_cyc;
      chk("b2b_wr_latency", 32'(dok_cyc - a2), EARLY ? 32'd2 : 32'd6);
      chk("b2b_wr_addr_ok_after_b", 32'(a3 - a2), 32'd6);
      @(posedge clk); #1 req = 1'b0;
      wait_dok(d0 + 3);
      chk("b2b_dok_count", 32'(dok_cnt - d0), 32'd3);

      // Abort a read in its data phase with reset (bus_err is set from earlier vectors)
      @(posedge clk); #1;
      r_dly = 8; b_dly = 0;
      d0 = dok_cnt;
      drive(1'b0, 2'd2, 32'h0000_0200, 32'd0, 4'hF);
      wait_acc();
      @(posedge clk); #1 req = 1'b0;
      for (int k = 0; k < 20 && !rready; k++) @(negedge clk);
      chk1("abort_reached_rd_d", rready, 1'b1);
      @(posedge clk); #3 resetn = 1'b0;
      #1;
      chk1("abort_arvalid", arvalid, 1'b0);
      chk1("abort_rready", rready, 1'b0);
      chk1("abort_data_ok", data_ok, 1'b0);
      chk1("abort_bus_err", bus_err, 1'b0);
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1; r_dly = 0; r_val = 32'h7777_8888;
      repeat (4) @(negedge clk);
      #1 chk("abort_no_stale_dok", 32'(dok_cnt), 32'(d0));
      @(posedge clk); #1;
      t0 = cyc;
      drive(1'b0, 2'd2, 32'h0000_0300, 32'd0, 4'hF);
      wait_acc();
      chk("post_reset_accept", 32'(acc_cyc - t0), 32'd0);
      @(posedge clk); #1 req = 1'b0;
      wait_dok(d0 + 1);
      chk("post_reset_latency", 32'(dok_cyc - acc_cyc), 32'd3);
      chk("post_reset_rdata", dok_rdata, 32'h7777_8888);
      repeat (3) @(posedge clk);
      #1 chk("final_dok_count", 32'(dok_cnt), 32'(d0 + 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
